// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit sides.
package uart_pkg;
  localparam int         OVERSAMPLE  = 16;
  localparam logic [3:0] MID_SAMPLE  = 4'd7;
  localparam logic [1:0] DBITS_5     = 2'd0;
  localparam logic [1:0] DBITS_6     = 2'd1;
  localparam logic [1:0] DBITS_7     = 2'd2;
  localparam logic [1:0] DBITS_8     = 2'd3;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } rx_frame_t;

  // Index of the final data bit for a data_bits code (5..8 bits -> 4..7).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] db);
    return 3'd4 + {1'b0, db};
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every baud_div clocks, restartable to align phase.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] reload;

  // A divisor of 0 behaves like 1 (tick every clock).
  assign reload = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= reload;
      tick <= 1'b0;
    end else if (cnt == '0) begin
      cnt  <= reload;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt - DIV_W'(1);
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF sync, 16x oversampled deframer, one-entry valid/ready output register.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_bits,
  input  logic             parity_en,
  input  logic             parity_odd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun,
  output logic             busy
);
  localparam logic [3:0] SC_LAST = 4'(OVERSAMPLE - 1);

  uart_state_e state, state_nxt;
  logic        rx_meta, rx_s;
  logic        tick, restart;
  logic [3:0]  sc;
  logic [2:0]  bc, last_idx;
  logic [7:0]  sh;
  logic        par, perr;
  logic [1:0]  cfg_bits;
  logic        cfg_pen, cfg_odd;
  logic        deliver;
  rx_frame_t   frm;

  assign last_idx = last_bit_idx(cfg_bits);
  assign busy     = (state != IDLE);

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .baud_div (baud_div),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    case (state)
      IDLE:   if (!rx_s) begin state_nxt = START; restart = 1'b1; end
      START:  if (tick && sc == MID_SAMPLE) state_nxt = rx_s ? IDLE : DATA;
      DATA:   if (tick && sc == SC_LAST && bc == last_idx) state_nxt = cfg_pen ? PARITY : STOP;
      PARITY: if (tick && sc == SC_LAST) state_nxt = STOP;
      STOP:   if (tick && sc == SC_LAST) state_nxt = rx_s ? IDLE : BREAK;
      BREAK:  if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      sc         <= '0;
      bc         <= '0;
      sh         <= '0;
      par        <= 1'b0;
      perr       <= 1'b0;
      cfg_bits   <= '0;
      cfg_pen    <= 1'b0;
      cfg_odd    <= 1'b0;
      deliver    <= 1'b0;
      frm        <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      deliver <= 1'b0;
      overrun <= 1'b0;

      // Config is frozen at start detect so mid-frame changes only hit the next frame.
      if (state == IDLE && !rx_s) begin
        sc       <= '0;
        bc       <= '0;
        par      <= 1'b0;
        perr     <= 1'b0;
        cfg_bits <= data_bits;
        cfg_pen  <= parity_en;
        cfg_odd  <= parity_odd;
      end else if (tick) begin
        case (state)
          START: sc <= (sc == MID_SAMPLE) ? 4'd0 : sc + 4'd1;
          DATA: begin
            sc <= sc + 4'd1;
            if (sc == SC_LAST) begin
              sh  <= {rx_s, sh[7:1]};
              par <= par ^ rx_s;
              bc  <= bc + 3'd1;
            end
          end
          PARITY: begin
            sc <= sc + 4'd1;
            if (sc == SC_LAST) perr <= (rx_s != (par ^ cfg_odd));
          end
          STOP: begin
            sc <= sc + 4'd1;
            if (sc == SC_LAST) begin
              deliver  <= 1'b1;
              // Bits arrive at the MSB end; shift down to right-align short words.
              frm.data <= sh >> (3'd7 - last_idx);
              frm.ferr <= !rx_s;
              frm.perr <= perr;
            end
          end
          default: ;
        endcase
      end

      if (deliver && (!rx_valid || rx_ready)) begin
        rx_valid   <= 1'b1;
        rx_data    <= frm.data;
        frame_err  <= frm.ferr;
        parity_err <= frm.perr;
      end else begin
        if (deliver)              overrun  <= 1'b1;
        if (rx_valid && rx_ready) rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames, monitor pops expectations on each handshake.
module tb_uart_rx_core;
  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] baud_div = 16'd54;
  logic [1:0]  data_bits = 2'd3;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b1;
  logic        frame_err, parity_err, overrun, busy;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   ovr_cnt = 0;

  uart_rx_core #(.OVERSAMPLE(16), .DIV_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .baud_div   (baud_div),
    .data_bits  (data_bits),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) ovr_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_rx: got %02h with nothing expected", rx_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          chk("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
          chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        end
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1);
  end

  function automatic int bitlen();
    return 16 * ((baud_div == 16'd0) ? 1 : int'(baud_div));
  endfunction

  task automatic drive_bit(input logic b, input int bl);
    rx = b;
    repeat (bl) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input int n, input bit pen, input bit pbit,
                      input bit stopb);
    int bl;
    bl = bitlen();
    drive_bit(1'b0, bl);
    for (int i = 0; i < n; i++) drive_bit(d[i], bl);
    if (pen) drive_bit(pbit, bl);
    drive_bit(stopb, bl);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.data = d; e.ferr = fe; e.perr = pe;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, rx_valid}, 0);
    chk("rst_data", {24'd0, rx_data}, 0);
    chk("rst_errs", {30'd0, frame_err, parity_err}, 0);
    chk("rst_ovr_busy", {30'd0, overrun, busy}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0xA5 at baud_div=54
    expect_frame(8'hA5, 0, 0);
    send(8'hA5, 8, 0, 0, 1);
    drain("t1_drain");

    // Start glitch: 4 ticks low must not produce output
    rx = 1'b0;
    repeat (216) @(negedge clk);
    chk("glitch_busy", {31'd0, busy}, 1);
    rx = 1'b1;
    n = 0;
    while (busy && n < 648) begin @(negedge clk); n++; end
    chk("glitch_idle", {31'd0, busy}, 0);
    repeat (20) @(negedge clk);

    // Faster baud for the remaining cases
    baud_div = 16'd10;

    // 7E with wrong parity bit
    data_bits = 2'd2; parity_en = 1'b1; parity_odd = 1'b0;
    expect_frame(8'h3C, 0, 1);
    send(8'h3C, 7, 1, 1, 1);
    drain("t2_drain");

    // 5O correct parity; config changed mid-frame must not apply
    data_bits = 2'd0; parity_en = 1'b1; parity_odd = 1'b1;
    expect_frame(8'h15, 0, 0);
    fork
      send(8'h15, 5, 1, 0, 1);
      begin
        repeat (320) @(negedge clk);
        data_bits = 2'd3; parity_en = 1'b0; parity_odd = 1'b0;
      end
    join
    drain("t5bit_drain");

    // Break: stop bit 0, line held low
    expect_frame(8'h00, 1, 0);
    send(8'h00, 8, 0, 0, 0);
    repeat (480) @(negedge clk);
    chk("break_busy", {31'd0, busy}, 1);
    drain("t4_drain");
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("break_exit", {31'd0, busy}, 0);
    expect_frame(8'h55, 0, 0);
    send(8'h55, 8, 0, 0, 1);
    drain("t4b_drain");

    // Overrun: consumer stalled across two frames
    rx_ready = 1'b0;
    n = ovr_cnt;
    expect_frame(8'h11, 0, 0);
    send(8'h11, 8, 0, 0, 1);
    send(8'h22, 8, 0, 0, 1);
    repeat (5) @(negedge clk);
    chk("ovr_valid", {31'd0, rx_valid}, 1);
    chk("ovr_held", {24'd0, rx_data}, 32'h11);
    chk("ovr_pulse", ovr_cnt - n, 1);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("ovr_release", {31'd0, rx_valid}, 0);
    drain("t5_drain");

    // Reset mid-frame with a held output word
    rx_ready = 1'b0;
    send(8'h5A, 8, 0, 0, 1);
    repeat (5) @(negedge clk);
    chk("pre_rst_valid", {31'd0, rx_valid}, 1);
    drive_bit(1'b0, 160);
    drive_bit(1'b1, 160);
    drive_bit(1'b0, 160);
    rst = 1'b1; rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_valid", {31'd0, rx_valid}, 0);
    chk("mid_rst_data", {24'd0, rx_data}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    rx_ready = 1'b1;
    repeat (20) @(negedge clk);
    expect_frame(8'hC3, 0, 0);
    send(8'hC3, 8, 0, 0, 1);
    drain("t6_drain");

    // Divisor 0 behaves as 1
    baud_div = 16'd0;
    repeat (10) @(negedge clk);
    expect_frame(8'h81, 0, 0);
    send(8'h81, 8, 0, 0, 1);
    drain("div0_drain");

    repeat (20) @(negedge clk);
    chk("total_overruns", ovr_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
